// File: rtl/minmax_tracker_4_bit_pkg.sv
// Shared definitions for the min/max frame tracker.
//   - mm_state_e : FSM state encoding (Idle, Accum, Hold)
//   - CntWDefault: default width of the saturating sample counter
package minmax_tracker_4_bit_pkg;

  localparam int unsigned CntWDefault = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAccum = 2'b01,
    StHold  = 2'b10
  } mm_state_e;

endpackage

// File: rtl/comp_4_bit.sv
// Gate-level 4-bit unsigned magnitude comparator.
//   A, B    : operands
//   A_GT_B  : A > B
//   A_LT_B  : A < B
//   A_EQ_B  : A == B
module comp_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       A_GT_B,
  output logic       A_LT_B,
  output logic       A_EQ_B
);

  logic [3:0] x;  // per-bit equality

  assign x = ~(A ^ B);

  assign A_GT_B = (A[3] & ~B[3])
                | (x[3] & A[2] & ~B[2])
                | (x[3] & x[2] & A[1] & ~B[1])
                | (x[3] & x[2] & x[1] & A[0] & ~B[0]);

  assign A_LT_B = (~A[3] & B[3])
                | (x[3] & ~A[2] & B[2])
                | (x[3] & x[2] & ~A[1] & B[1])
                | (x[3] & x[2] & x[1] & ~A[0] & B[0]);

  assign A_EQ_B = &x;

endmodule

// File: rtl/minmax_tracker_4_bit.sv
// Tracks the minimum, maximum and sample count of a frame of 4-bit unsigned
// samples, then holds the result until the downstream handshake completes.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : sample handshake; in_data sample, in_last ends frame
//   out_valid/out_ready   : result handshake
//   out_min/out_max       : frame extremes
//   out_count             : samples in frame, saturating at 2^CNT_W-1
//   out_eq                : all samples in the frame were equal
module minmax_tracker_4_bit
  import minmax_tracker_4_bit_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_min,
  output logic [3:0]       out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_eq
);

  mm_state_e        state_q, state_d;
  logic [3:0]       min_q, min_d;
  logic [3:0]       max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             eq_q, eq_d;

  logic gt_min, lt_min, eq_min;
  logic gt_max, lt_max, eq_max;
  logic accept;
  logic unused_eq_flags;

  comp_4_bit u_cmp_min (
    .A      (in_data),
    .B      (min_q),
    .A_GT_B (gt_min),
    .A_LT_B (lt_min),
    .A_EQ_B (eq_min)
  );

  comp_4_bit u_cmp_max (
    .A      (in_data),
    .B      (max_q),
    .A_GT_B (gt_max),
    .A_LT_B (lt_max),
    .A_EQ_B (eq_max)
  );

  // Equality is derived from the GT/LT flags; EQ outputs are not needed.
  assign unused_eq_flags = eq_min ^ eq_max;

  assign in_ready = (state_q != StHold);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          min_d   = in_data;
          max_d   = in_data;
          count_d = CNT_W'(1);
          if (in_last) begin
            eq_d    = 1'b1;
            state_d = StHold;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (accept) begin
          if (lt_min) min_d = in_data;
          if (gt_max) max_d = in_data;
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
          if (in_last) begin
            // min==max after update only if the sample equals both extremes.
            eq_d    = ~(gt_min | lt_min | gt_max | lt_max);
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      min_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
      eq_q    <= eq_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;
  assign out_eq    = eq_q;

endmodule

// File: tb/tb_minmax_tracker_4_bit.sv
module tb_minmax_tracker_4_bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_eq;
  logic [3:0] a_out_min, a_out_max, a_out_count;
  logic       b_in_ready, b_out_valid, b_out_eq;
  logic [3:0] b_out_min, b_out_max;
  logic [1:0] b_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minmax_tracker_4_bit u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_min   (a_out_min),
    .out_max   (a_out_max),
    .out_count (a_out_count),
    .out_eq    (a_out_eq)
  );

  minmax_tracker_4_bit #(.CNT_W(2)) u_dut_w2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_min   (b_out_min),
    .out_max   (b_out_max),
    .out_count (b_out_count),
    .out_eq    (b_out_eq)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_valid", a_out_valid, 0);
    check("release_ready", a_in_ready, 1);
  endtask

  task automatic check_result(input string tag, input int unsigned mn, input int unsigned mx,
                              input int unsigned cnt, input int unsigned eq);
    check({tag, "_valid"}, a_out_valid, 1);
    check({tag, "_min"}, a_out_min, mn);
    check({tag, "_max"}, a_out_max, mx);
    check({tag, "_count"}, a_out_count, cnt);
    check({tag, "_eq"}, a_out_eq, eq);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", a_out_valid, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_min", a_out_min, 0);
    check("rst_max", a_out_max, 0);
    check("rst_count", a_out_count, 0);
    check("rst_eq", a_out_eq, 0);

    // in_last without in_valid is ignored; out_ready outside HOLD is ignored.
    in_last = 1'b1; out_ready = 1'b1;
    step();
    in_last = 1'b0; out_ready = 1'b0;
    check("lone_last_valid", a_out_valid, 0);
    check("lone_last_ready", a_in_ready, 1);

    // Frame 5,2,9,9(last)
    push(4'd5, 1'b0);
    push(4'd2, 1'b0);
    push(4'd9, 1'b0);
    check("f1_not_yet", a_out_valid, 0);
    push(4'd9, 1'b1);
    check_result("f1", 2, 9, 4, 0);
    check("f1_hold_ready", a_in_ready, 0);
    release_result();

    // Single sample 7(last)
    push(4'd7, 1'b1);
    check_result("f2", 7, 7, 1, 1);
    release_result();

    // Six samples of 3: 4-bit counter reaches 6, 2-bit counter saturates at 3
    for (int i = 0; i < 6; i++) push(4'd3, (i == 5));
    check_result("f3", 3, 3, 6, 1);
    check("f3w2_valid", b_out_valid, 1);
    check("f3w2_count", b_out_count, 3);
    check("f3w2_eq", b_out_eq, 1);
    check("f3w2_min", b_out_min, 3);
    check("f3w2_max", b_out_max, 3);
    release_result();

    // Held result with upstream pushing: no acceptance, outputs stable
    push(4'd4, 1'b1);
    in_valid = 1'b1; in_data = 4'd11; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_ready", a_in_ready, 0);
      check("hold_min", a_out_min, 4);
      check("hold_max", a_out_max, 4);
      check("hold_count", a_out_count, 1);
      check("hold_valid", a_out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold_exit_valid", a_out_valid, 0);
    check("hold_exit_ready", a_in_ready, 1);
    check("hold_no_bypass", a_out_min, 4);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check_result("f4", 11, 11, 1, 1);
    release_result();

    // Reset aborts a partial frame
    push(4'd4, 1'b0);
    push(4'd1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", a_out_valid, 0);
    check("abort_count", a_out_count, 0);
    check("abort_min", a_out_min, 0);
    push(4'd8, 1'b1);
    check_result("f5", 8, 8, 1, 1);
    release_result();

    // Boundary values
    push(4'd0, 1'b0);
    push(4'd15, 1'b0);
    push(4'd0, 1'b1);
    check_result("f6", 0, 15, 3, 0);
    release_result();

    // Descending then ascending extremes in the interior of a frame
    push(4'd8, 1'b0);
    push(4'd6, 1'b0);
    push(4'd12, 1'b0);
    push(4'd7, 1'b1);
    check_result("f7", 6, 12, 4, 0);

    // Reset while holding discards the result
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_hold_valid", a_out_valid, 0);
    check("rst_hold_ready", a_in_ready, 1);
    check("rst_hold_eq", a_out_eq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
